// File: rtl/riscv_alu_core.sv
// RV32I integer ALU with a single registered output stage.
// Result, zero flag and valid are presented one clock after an accepted request.
module riscv_alu_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_alu_valid,
  input  logic [XLEN-1:0] i_alu_a,
  input  logic [XLEN-1:0] i_alu_b,
  input  logic [4:0]      i_alu_ctrl,
  output logic            o_alu_valid,
  output logic [XLEN-1:0] o_alu_result,
  output logic            o_alu_zero
);

  localparam int unsigned ShW = $clog2(XLEN);

  localparam logic [4:0] CtrlAdd  = 5'h00;
  localparam logic [4:0] CtrlSll  = 5'h01;
  localparam logic [4:0] CtrlSlt  = 5'h02;
  localparam logic [4:0] CtrlSltu = 5'h03;
  localparam logic [4:0] CtrlXor  = 5'h04;
  localparam logic [4:0] CtrlSrl  = 5'h05;
  localparam logic [4:0] CtrlOr   = 5'h06;
  localparam logic [4:0] CtrlAnd  = 5'h07;
  localparam logic [4:0] CtrlSub  = 5'h08;
  localparam logic [4:0] CtrlSra  = 5'h0D;

  logic            w_sub;
  logic [XLEN-1:0] w_b_op;
  logic [XLEN:0]   w_sum;
  logic            w_ltu;
  logic            w_lts;
  logic [ShW-1:0]  w_shamt;
  logic [XLEN-1:0] w_result;

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  // One adder serves ADD, SUB and both compares (a + ~b + 1).
  assign w_sub   = (i_alu_ctrl == CtrlSub) || (i_alu_ctrl == CtrlSlt) || (i_alu_ctrl == CtrlSltu);
  assign w_b_op  = w_sub ? ~i_alu_b : i_alu_b;
  assign w_sum   = {1'b0, i_alu_a} + {1'b0, w_b_op} + {{XLEN{1'b0}}, w_sub};
  // No carry out of a - b means a borrow, i.e. a < b unsigned.
  assign w_ltu   = ~w_sum[XLEN];
  assign w_lts   = (i_alu_a[XLEN-1] != i_alu_b[XLEN-1]) ? i_alu_a[XLEN-1] : w_sum[XLEN-1];
  assign w_shamt = i_alu_b[ShW-1:0];

  always_comb begin
    w_result = '0;
    case (i_alu_ctrl)
      CtrlAdd,
      CtrlSub:  w_result = w_sum[XLEN-1:0];
      CtrlSll:  w_result = i_alu_a << w_shamt;
      CtrlSlt:  w_result = {{(XLEN-1){1'b0}}, w_lts};
      CtrlSltu: w_result = {{(XLEN-1){1'b0}}, w_ltu};
      CtrlXor:  w_result = i_alu_a ^ i_alu_b;
      CtrlSrl:  w_result = i_alu_a >> w_shamt;
      CtrlOr:   w_result = i_alu_a | i_alu_b;
      CtrlAnd:  w_result = i_alu_a & i_alu_b;
      CtrlSra:  w_result = $unsigned($signed(i_alu_a) >>> w_shamt);
      default:  w_result = '0;
    endcase
  end

  // Result and zero hold while idle; only valid drops.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_valid <= i_alu_valid;
      if (i_alu_valid) begin
        r_result <= w_result;
        r_zero   <= (w_result == '0);
      end
    end
  end

  assign o_alu_valid  = r_valid;
  assign o_alu_result = r_result;
  assign o_alu_zero   = r_zero;

endmodule

// File: tb/tb_riscv_alu_core.sv
// Self-checking bench for riscv_alu_core: directed steps plus randomised ops,
// with expected results queued at issue and compared when the output appears.
module tb_riscv_alu_core;

  logic        clk;
  logic        rstn;
  logic        alu_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_ctrl;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_zero;

  typedef struct {
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_res;
  logic        last_z;
  int          checks;
  int          errors;

  riscv_alu_core #(.XLEN(32)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_alu_valid  (alu_valid),
    .i_alu_a      (alu_a),
    .i_alu_b      (alu_b),
    .i_alu_ctrl   (alu_ctrl),
    .o_alu_valid  (o_valid),
    .o_alu_result (o_result),
    .o_alu_zero   (o_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (c)
      5'h00:   r = a + b;
      5'h08:   r = a - b;
      5'h01:   r = a << b[4:0];
      5'h02:   r = {31'b0, ($signed(a) < $signed(b))};
      5'h03:   r = {31'b0, (a < b)};
      5'h04:   r = a ^ b;
      5'h05:   r = a >> b[4:0];
      5'h06:   r = a | b;
      5'h07:   r = a & b;
      5'h0D:   r = 32'($signed(a) >>> b[4:0]);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check the registered outputs just after the rising edge.
  task automatic step(input string tag, input logic v, input logic [4:0] c,
                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    alu_valid = v;
    alu_ctrl  = c;
    alu_a     = a;
    alu_b     = b;
    if (v) begin
      e.res = ref_alu(c, a, b);
      e.z   = (e.res == 32'h0);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {31'b0, o_valid}, {31'b0, v});
    if (v) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'h1, 32'h0);
      end else begin
        e        = sb.pop_front();
        last_res = e.res;
        last_z   = e.z;
      end
    end
    chk({tag, "_result"}, o_result, last_res);
    chk({tag, "_zero"}, {31'b0, o_zero}, {31'b0, last_z});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'b0, o_valid}, 32'h0);
    chk({tag, "_result"}, o_result, 32'h0);
    chk({tag, "_zero"}, {31'b0, o_zero}, 32'h1);
  endtask

  logic [4:0] codes[10];

  initial begin
    checks    = 0;
    errors    = 0;
    last_res  = 32'h0;
    last_z    = 1'b1;
    codes     = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h0D};
    rstn      = 1'b0;
    alu_valid = 1'b0;
    alu_ctrl  = 5'h0;
    alu_a     = 32'h0;
    alu_b     = 32'h0;

    // Requests during reset must be ignored.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      alu_valid = 1'b1;
      alu_ctrl  = 5'h00;
      alu_a     = 32'h1234;
      alu_b     = 32'h1;
      @(posedge clk);
      #1;
      chk_reset_vals("rst_hold");
    end
    @(negedge clk);
    rstn      = 1'b1;
    alu_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("rst_release");

    step("add_wrap", 1'b1, 5'h00, 32'hFFFF_FFFF, 32'h1);
    step("sub_neg",  1'b1, 5'h08, 32'h5, 32'h7);
    step("slt_neg",  1'b1, 5'h02, 32'h8000_0000, 32'h1);
    step("sltu",     1'b1, 5'h03, 32'h8000_0000, 32'h1);
    step("slt_eq",   1'b1, 5'h02, 32'h3, 32'h3);
    step("sra4",     1'b1, 5'h0D, 32'h8000_0000, 32'h4);
    step("srl4",     1'b1, 5'h05, 32'h8000_0000, 32'h4);
    step("sll33",    1'b1, 5'h01, 32'h1, 32'd33);
    step("sra0",     1'b1, 5'h0D, 32'h8000_0000, 32'h0);
    step("xor",      1'b1, 5'h04, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step("or",       1'b1, 5'h06, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step("and",      1'b1, 5'h07, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step("idle_hold", 1'b0, 5'h00, 32'h1, 32'h1);
    step("bad_ctrl", 1'b1, 5'h1F, 32'hDEAD_BEEF, 32'h1234_5678);

    // Directed literal checks on top of the model for a few known answers.
    step("add_known", 1'b1, 5'h00, 32'h7, 32'h8);
    chk("add_known_lit", o_result, 32'hF);
    step("sra_known", 1'b1, 5'h0D, 32'h8000_0000, 32'h4);
    chk("sra_known_lit", o_result, 32'hF800_0000);

    for (int i = 0; i < 1000; i++) begin
      logic        v;
      logic [4:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : codes[$urandom_range(0, 9)];
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      step("rand", v, c, a, b);
      if (i == 500) begin
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        sb.delete();
        last_res = 32'h0;
        last_z   = 1'b1;
        @(negedge clk);
        alu_valid = 1'b0;
        rstn      = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
